token_to_uint: RTL and testbench

TOKEN_TO_UINT -- requirements
Module: token_to_uint

---
 rtl/token_to_uint_if.sv | 23 ++
 rtl/token_to_uint.sv | 183 ++++++++++++++++++
 tb/tb_token_to_uint.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/token_to_uint_if.sv
// Handshake bundle between a tokenizer front end and the token_to_uint converter.
// The master drives the request (START/TOKEN); the slave returns status and result.
interface token_to_uint_if #(
  parameter int TOKEN_WIDTH  = 256,
  parameter int RESULT_WIDTH = 32
);
  logic                    START;
  logic [TOKEN_WIDTH-1:0]  TOKEN;
  logic                    BUSY;
  logic                    DONE;
  logic [RESULT_WIDTH-1:0] RESULT;
  logic [1:0]              STATUS;

  modport master (
    output START, TOKEN,
    input  BUSY, DONE, RESULT, STATUS
  );

  modport slave (
    input  START, TOKEN,
    output BUSY, DONE, RESULT, STATUS
  );
endinterface

// File: rtl/token_to_uint.sv
// Converts a right-justified, zero-padded ASCII number token (decimal or 0x-hex)
// into an unsigned integer, one byte per clock, with empty/bad-char/overflow status.
module token_to_uint #(
  parameter int TOKEN_WIDTH  = 256,
  parameter int RESULT_WIDTH = 32
) (
  input  logic            AXI_ACLK,
  input  logic            AXI_ARESETN,
  token_to_uint_if.slave  bus
);
  localparam int TOKEN_BYTES = TOKEN_WIDTH / 8;
  localparam int CNT_W       = $clog2(TOKEN_BYTES + 1);
  localparam int WIDE_W      = RESULT_WIDTH + 5;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SKIP_PAD = 2'd1;
  localparam logic [1:0] ST_PREFIX   = 2'd2;
  localparam logic [1:0] ST_DIGITS   = 2'd3;

  localparam logic [1:0] STAT_OK       = 2'd0;
  localparam logic [1:0] STAT_EMPTY    = 2'd1;
  localparam logic [1:0] STAT_BAD_CHAR = 2'd2;
  localparam logic [1:0] STAT_OVERFLOW = 2'd3;

  logic [1:0]              state_reg,  state_next;
  logic [TOKEN_WIDTH-1:0]  sr_reg,     sr_next;
  logic [CNT_W-1:0]        cnt_reg,    cnt_next;
  logic [RESULT_WIDTH-1:0] acc_reg,    acc_next;
  logic                    hex_reg,    hex_next;
  logic                    seen_reg,   seen_next;
  logic                    busy_reg,   busy_next;
  logic                    done_reg,   done_next;
  logic [RESULT_WIDTH-1:0] result_reg, result_next;
  logic [1:0]              status_reg, status_next;

  logic [7:0]        top_byte;
  logic [7:0]        next_byte;
  logic              digit_ok;
  logic [3:0]        digit_val;
  logic [WIDE_W-1:0] acc_wide;
  logic [WIDE_W-1:0] acc_mul;
  logic [WIDE_W-1:0] acc_sum;
  logic              acc_ovf;

  assign top_byte  = sr_reg[TOKEN_WIDTH-1 -: 8];
  assign next_byte = sr_reg[TOKEN_WIDTH-9 -: 8];

  // Hex letters share low-nibble layout: 'A'/'a' = x1, so value = nibble + 9.
  always_comb begin
    digit_ok  = 1'b0;
    digit_val = 4'd0;
    if (top_byte >= 8'h30 && top_byte <= 8'h39) begin
      digit_ok  = 1'b1;
      digit_val = top_byte[3:0];
    end else if (hex_reg && ((top_byte >= 8'h61 && top_byte <= 8'h66) ||
                             (top_byte >= 8'h41 && top_byte <= 8'h46))) begin
      digit_ok  = 1'b1;
      digit_val = top_byte[3:0] + 4'd9;
    end
  end

  // Extra headroom bits catch any carry past RESULT_WIDTH.
  assign acc_wide = WIDE_W'(acc_reg);
  assign acc_mul  = hex_reg ? (acc_wide << 4) : ((acc_wide << 3) + (acc_wide << 1));
  assign acc_sum  = acc_mul + WIDE_W'(digit_val);
  assign acc_ovf  = |acc_sum[WIDE_W-1:RESULT_WIDTH];

  always_comb begin
    state_next  = state_reg;
    sr_next     = sr_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    hex_next    = hex_reg;
    seen_next   = seen_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    result_next = result_reg;
    status_next = status_reg;

    case (state_reg)
      ST_IDLE: begin
        // A START coinciding with the DONE pulse belongs to the finishing job; drop it.
        if (bus.START && !done_reg) begin
          sr_next    = bus.TOKEN;
          cnt_next   = CNT_W'(TOKEN_BYTES);
          acc_next   = '0;
          hex_next   = 1'b0;
          seen_next  = 1'b0;
          busy_next  = 1'b1;
          state_next = ST_SKIP_PAD;
        end
      end

      ST_SKIP_PAD: begin
        if (cnt_reg == '0) begin
          done_next   = 1'b1;
          busy_next   = 1'b0;
          status_next = STAT_EMPTY;
          result_next = '0;
          state_next  = ST_IDLE;
        end else if (top_byte == 8'h00) begin
          sr_next  = sr_reg << 8;
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next = ST_PREFIX;
        end
      end

      ST_PREFIX: begin
        if (cnt_reg >= CNT_W'(2) && top_byte == 8'h30 &&
            (next_byte == 8'h78 || next_byte == 8'h58)) begin
          hex_next = 1'b1;
          sr_next  = sr_reg << 16;
          cnt_next = cnt_reg - CNT_W'(2);
        end
        state_next = ST_DIGITS;
      end

      ST_DIGITS: begin
        if (cnt_reg == '0) begin
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = ST_IDLE;
          status_next = seen_reg ? STAT_OK : STAT_BAD_CHAR;
          result_next = seen_reg ? acc_reg : '0;
        end else if (!digit_ok) begin
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = ST_IDLE;
          status_next = STAT_BAD_CHAR;
          result_next = acc_reg;
        end else if (acc_ovf) begin
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = ST_IDLE;
          status_next = STAT_OVERFLOW;
          result_next = '1;
        end else begin
          acc_next  = acc_sum[RESULT_WIDTH-1:0];
          seen_next = 1'b1;
          sr_next   = sr_reg << 8;
          cnt_next  = cnt_reg - CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state_reg  <= ST_IDLE;
      sr_reg     <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      hex_reg    <= 1'b0;
      seen_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      status_reg <= STAT_OK;
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      hex_reg    <= hex_next;
      seen_reg   <= seen_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      result_reg <= result_next;
      status_reg <= status_next;
    end
  end

  assign bus.BUSY   = busy_reg;
  assign bus.DONE   = done_reg;
  assign bus.RESULT = result_reg;
  assign bus.STATUS = status_reg;
endmodule

// File: tb/tb_token_to_uint.sv
// Directed scoreboard bench for token_to_uint: stimulus pushes expected
// result/status/latency, a negedge monitor pops and compares on every DONE.
module tb_token_to_uint;
  localparam int TW = 256;
  localparam int RW = 32;

  typedef struct {
    logic [RW-1:0] res;
    logic [1:0]    stat;
    int            start_edge;
    int            lat;
  } exp_t;

  logic AXI_ACLK = 1'b0;
  logic AXI_ARESETN = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  token_to_uint_if #(.TOKEN_WIDTH(TW), .RESULT_WIDTH(RW)) bus ();

  token_to_uint #(.TOKEN_WIDTH(TW), .RESULT_WIDTH(RW)) dut (
    .AXI_ACLK    (AXI_ACLK),
    .AXI_ARESETN (AXI_ARESETN),
    .bus         (bus)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;
  always @(posedge AXI_ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [TW-1:0] mk(input string s);
    logic [TW-1:0] t = '0;
    for (int i = 0; i < s.len(); i++) t = (t << 8) | TW'(s[i]);
    return t;
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge AXI_ACLK) begin
    if (AXI_ARESETN && bus.DONE) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(bus.RESULT), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result",  64'(bus.RESULT), 64'(e.res));
        chk("status",  64'(bus.STATUS), 64'(e.stat));
        chk("latency", 64'(cyc - e.start_edge), 64'(e.lat));
        chk("busy_with_done", 64'(bus.BUSY), 64'd0);
        $display("txn: result=0x%0h status=%0d latency=%0d", bus.RESULT, bus.STATUS, cyc - e.start_edge);
      end
    end
  end

  // Called on a negedge: the pulse is sampled on the next rising edge.
  task automatic issue(input logic [TW-1:0] tok, input logic [RW-1:0] res,
                       input logic [1:0] stat, input int lat);
    exp_t e;
    e.res = res; e.stat = stat; e.start_edge = cyc + 1; e.lat = lat;
    sb_q.push_back(e);
    bus.START = 1'b1;
    bus.TOKEN = tok;
    @(negedge AXI_ACLK);
    bus.START = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge AXI_ACLK);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("timeout_no_done", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge AXI_ACLK);
  endtask

  task automatic run(input logic [TW-1:0] tok, input logic [RW-1:0] res,
                     input logic [1:0] stat, input int lat);
    issue(tok, res, stat, lat);
    wait_idle();
  endtask

  initial begin
    logic [TW-1:0] nul_tok;
    int start_edge;
    int n;

    bus.START = 1'b0;
    bus.TOKEN = '0;
    repeat (3) @(negedge AXI_ACLK);
    chk("reset_busy",   64'(bus.BUSY),   64'd0);
    chk("reset_done",   64'(bus.DONE),   64'd0);
    chk("reset_result", 64'(bus.RESULT), 64'd0);
    chk("reset_status", 64'(bus.STATUS), 64'd0);

    // Release reset and START on the same edge: first START must be taken.
    AXI_ARESETN = 1'b1;
    run(mk("123"), 32'd123, 2'd0, 35);
    run(mk("0x1F"), 32'd31, 2'd0, 33);
    run(mk("0X1f"), 32'd31, 2'd0, 33);
    run(mk("4294967295"), 32'hFFFF_FFFF, 2'd0, 35);
    run(mk("4294967296"), 32'hFFFF_FFFF, 2'd3, 34);
    run(mk("12a"), 32'd12, 2'd2, 34);
    run(mk("0x"), 32'd0, 2'd2, 33);
    run('0, 32'd0, 2'd1, 33);
    run(mk("0"), 32'd0, 2'd0, 35);
    run(mk("07"), 32'd7, 2'd0, 35);
    run(mk("0xffffffff"), 32'hFFFF_FFFF, 2'd0, 33);
    run(mk("0x100000000"), 32'hFFFF_FFFF, 2'd3, 32);
    nul_tok = '0;
    nul_tok[23:0] = 24'h31_00_32;
    run(nul_tok, 32'd1, 2'd2, 33);

    // Second START during a busy conversion must not disturb it.
    issue(mk("123"), 32'd123, 2'd0, 35);
    repeat (5) @(negedge AXI_ACLK);
    chk("busy_mid_conv", 64'(bus.BUSY), 64'd1);
    bus.START = 1'b1;
    bus.TOKEN = mk("555");
    @(negedge AXI_ACLK);
    bus.START = 1'b0;
    bus.TOKEN = '0;
    wait_idle();
    repeat (40) @(negedge AXI_ACLK);

    // START while DONE is high is dropped; RESULT holds afterwards.
    issue(mk("42"), 32'd42, 2'd0, 35);
    n = 0;
    while (!bus.DONE && n < 100) begin
      @(negedge AXI_ACLK);
      n++;
    end
    chk("done_seen", 64'(bus.DONE), 64'd1);
    bus.START = 1'b1;
    bus.TOKEN = mk("9");
    @(negedge AXI_ACLK);
    bus.START = 1'b0;
    chk("start_in_done_ignored", 64'(bus.BUSY), 64'd0);
    repeat (3) @(negedge AXI_ACLK);
    chk("result_hold", 64'(bus.RESULT), 64'd42);
    chk("status_hold", 64'(bus.STATUS), 64'd0);
    if (sb_q.size() != 0) sb_q.delete();

    // Reset asserted at edge 10 of a conversion: no DONE, outputs cleared.
    bus.START = 1'b1;
    bus.TOKEN = mk("999");
    start_edge = cyc + 1;
    @(negedge AXI_ACLK);
    bus.START = 1'b0;
    while (cyc + 1 < start_edge + 10) @(negedge AXI_ACLK);
    AXI_ARESETN = 1'b0;
    @(negedge AXI_ACLK);
    chk("midrst_busy",   64'(bus.BUSY),   64'd0);
    chk("midrst_done",   64'(bus.DONE),   64'd0);
    chk("midrst_result", 64'(bus.RESULT), 64'd0);
    chk("midrst_status", 64'(bus.STATUS), 64'd0);
    repeat (40) @(negedge AXI_ACLK);
    chk("midrst_still_idle", 64'(bus.BUSY), 64'd0);
    AXI_ARESETN = 1'b1;
    run(mk("7"), 32'd7, 2'd0, 35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
